// File: rtl/logic_gate_seq_unit.sv
// Registered 2-input gate unit: pairwise bitwise gate or left-to-right fold of a
// multi-beat stream, with valid/ready on both sides and a single output register.
module logic_gate_seq_unit #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNTW      = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic             err,
  output logic [CNTW-1:0]  beats
);

  typedef enum logic [1:0] {IDLE, FOLD, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [CNTW-1:0]  r_cnt;
  logic             r_ovf;

  logic             w_in_fire;
  logic             w_op_rsvd;
  logic             w_fold_rsvd;
  logic             w_cnt_max;
  logic [CNTW-1:0]  w_cnt_inc;
  logic [WIDTH-1:0] w_start_y;
  logic [WIDTH-1:0] w_fold_acc;
  logic [WIDTH-1:0] w_fold_y;

  function automatic logic [WIDTH-1:0] f_gate(input logic [2:0] g,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (g)
      3'd0:    return x & z;
      3'd1:    return ~(x & z);
      3'd2:    return ~(x | z);
      3'd3:    return x | z;
      3'd4:    return ~(x ^ z);
      3'd5:    return x ^ z;
      default: return '0;
    endcase
  endfunction

  // The only combinational input-to-output path: HOLD passes out_ready through.
  assign in_ready    = !rst && ((r_state != HOLD) || out_ready);
  assign w_in_fire   = in_valid && in_ready;
  assign w_op_rsvd   = op[2] & op[1];
  assign w_fold_rsvd = r_op[2] & r_op[1];
  assign w_cnt_max   = (r_cnt == CNTW'(MAX_BEATS));
  assign w_cnt_inc   = w_cnt_max ? r_cnt : r_cnt + CNTW'(1);
  assign w_start_y   = mode ? (w_op_rsvd ? '0 : a) : f_gate(op, a, b);
  assign w_fold_acc  = f_gate(r_op, r_acc, a);
  assign w_fold_y    = w_fold_rsvd ? '0 : w_fold_acc;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      y_zero    <= 1'b1;
      y_parity  <= 1'b0;
      err       <= 1'b0;
      beats     <= '0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (r_state == HOLD && out_ready && !in_valid) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
          if (w_in_fire) begin
            if (!mode || in_last) begin
              y         <= w_start_y;
              y_zero    <= ~|w_start_y;
              y_parity  <= ^w_start_y;
              err       <= w_op_rsvd;
              beats     <= CNTW'(1);
              out_valid <= 1'b1;
              r_state   <= HOLD;
            end else begin
              r_acc     <= a;
              r_op      <= op;
              r_cnt     <= CNTW'(1);
              r_ovf     <= 1'b0;
              out_valid <= 1'b0;
              r_state   <= FOLD;
            end
          end
        end
        FOLD: begin
          if (w_in_fire) begin
            r_acc <= w_fold_acc;
            r_cnt <= w_cnt_inc;
            if (w_cnt_max) r_ovf <= 1'b1;
            if (in_last) begin
              y         <= w_fold_y;
              y_zero    <= ~|w_fold_y;
              y_parity  <= ^w_fold_y;
              err       <= w_fold_rsvd | r_ovf | w_cnt_max;
              beats     <= w_cnt_inc;
              out_valid <= 1'b1;
              r_state   <= HOLD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
